pose2grid_stream: RTL and testbench
===================================

POSE2GRID_STREAM -- requirements
Module: pose2grid_stream

Interface
REQ-001 SHALL have parameters: POS_W 32, signed fixed-point coordinate width; FRAC_W 16, fraction bits; CELL_SHIFT 0, cell edge = 2^CELL_SHIFT integer units; GX_W 5, GY_W 6, GZ_W 5, grid index widths; ORIGIN_X/Y/Z 0, grid origin in coordinate units; CNT_W 16, counter width.
REQ-002 SHALL have ports: CLK in 1 clock; RST_n in 1 async active-low reset; start in 1 frame start pulse; pt_valid in 1; pt_ready out 1; pt_x/pt_y/pt_z in POS_W signed point; pt_last in 1 last point of frame; cell_valid out 1; cell_ready in 1; cell_x out GX_W; cell_y out GY_W; cell_z out GZ_W; busy out 1; frame_done out 1; pt_cnt out CNT_W; oob_cnt out CNT_W.

Function
REQ-003 SHALL implement states IDLE, ACCEPT, EMIT, DONE; IDLE->ACCEPT on start; ACCEPT->EMIT on point handshake; EMIT->ACCEPT after last sub-cell (EMIT->DONE if point had pt_last); DONE->IDLE after one cycle.
REQ-004 SHALL assert pt_ready only in ACCEPT; point transfers when pt_valid && pt_ready.
REQ-005 SHALL compute per axis d = coord - ORIGIN (POS_W+1 bits signed, no overflow) and idx = d >>> (FRAC_W+CELL_SHIFT) (arithmetic, floor).
REQ-006 SHALL treat an axis index as in-range when 0 <= idx <= 2^G*_W-1.
REQ-007 SHALL, without dilation, emit exactly one cell (idx_x, idx_y, idx_z) if all axes in range, else emit none and increment oob_cnt.
REQ-008 SHALL present first cell_valid in the cycle after point acceptance (latency 1); cell fields and cell_valid SHALL hold stable while cell_valid && !cell_ready.
REQ-009 SHALL increment pt_cnt per accepted point; both counters SHALL saturate at 2^CNT_W-1 and clear on accepted start.
REQ-010 SHALL pulse frame_done for one cycle in DONE; busy SHALL be high in ACCEPT, EMIT, DONE.
REQ-011 SHALL ignore start when not in IDLE; pt_valid in IDLE SHALL be ignored.
REQ-012 SHALL accept a pt_last point with all cells out of range: no cells emitted, oob_cnt incremented, DONE entered directly.

Reset
REQ-013 SHALL on RST_n low asynchronously force IDLE, sub-cell counter 0, and all outputs 0 (pt_ready, cell_valid, cell_*, busy, frame_done, pt_cnt, oob_cnt), including mid-EMIT.
REQ-014 SHALL release reset synchronously to CLK.

Configuration
REQ-015 SHALL with POSE2GRID_DILATE_EN defined compute base = (d - 2^(FRAC_W+CELL_SHIFT-1)) >>> (FRAC_W+CELL_SHIFT) per axis and step a 3-bit counter k=0..7, candidate = base + {k[0],k[1],k[2]} for x,y,z.
REQ-016 SHALL under POSE2GRID_DILATE_EN spend one EMIT cycle per out-of-range candidate with cell_valid low, emit in-range candidates in k order, and increment oob_cnt only if zero of 8 were in range.
REQ-017 SHALL without POSE2GRID_DILATE_EN contain no sub-cell counter and behave per REQ-007.

Structure
REQ-018 SHALL place state encoding, sub-cell offset ordering and saturating-increment function in package pose2grid_pkg.
REQ-019 SHALL use one sub-module, pose2grid_quant, for per-axis subtract/shift/range check, instantiated three times.

Verification (FRAC_W=16, CELL_SHIFT=0, origins 0)
REQ-020 No dilation: start, point (0x00030000,0x00050000,0x00070000) last -> one cell (3,5,7) cycle after accept, frame_done one cycle after handshake, pt_cnt=1, oob_cnt=0.
REQ-021 No dilation: point x=0xFFFF8000 (-0.5), last -> no cell_valid, oob_cnt=1, frame_done pulses.
REQ-022 Dilation: point (3.75,5.25,7.5) -> base (3,4,7); cells (3,4,7),(4,4,7),(3,5,7),(4,5,7),(3,4,8),(4,4,8),(3,5,8),(4,5,8) in order over 8 cycles with cell_ready=1.
REQ-023 Dilation: point (0.25,0.25,0.25) -> base (-1,-1,-1); only (0,0,0) emitted at k=7, 7 cycles cell_valid low, oob_cnt=0.
REQ-024 cell_ready low 5 cycles during EMIT -> cell fields stable, pt_ready low; RST_n low mid-EMIT -> all outputs 0 next sample, state IDLE, start required to resume.

Source files
------------

// File: rtl/pose2grid_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pose2grid_pkg: FSM encoding, dilation offset order, saturating step.
// Rev 1.0
// ------------------------------------------------------------------
package pose2grid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Returns {dx, dy, dz}; x toggles fastest so cells sweep x, then y, then z.
  function automatic logic [2:0] subOffset(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic [63:0] satInc(input logic [63:0] v, input int w);
    logic [63:0] maxVal;
    maxVal = (64'd1 << w) - 64'd1;
    return (v == maxVal) ? v : v + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pose2grid_stream_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pose2grid_stream_if: point input stream and cell output stream.
// Rev 1.0
// ------------------------------------------------------------------
interface pose2grid_stream_if #(
  parameter int POS_W = 32,
  parameter int GX_W  = 5,
  parameter int GY_W  = 6,
  parameter int GZ_W  = 5
);
  logic                    pt_valid;
  logic                    pt_ready;
  logic signed [POS_W-1:0] pt_x;
  logic signed [POS_W-1:0] pt_y;
  logic signed [POS_W-1:0] pt_z;
  logic                    pt_last;
  logic                    cell_valid;
  logic                    cell_ready;
  logic [GX_W-1:0]         cell_x;
  logic [GY_W-1:0]         cell_y;
  logic [GZ_W-1:0]         cell_z;

  modport master (
    output pt_valid, pt_x, pt_y, pt_z, pt_last, cell_ready,
    input  pt_ready, cell_valid, cell_x, cell_y, cell_z
  );

  modport slave (
    input  pt_valid, pt_x, pt_y, pt_z, pt_last, cell_ready,
    output pt_ready, cell_valid, cell_x, cell_y, cell_z
  );
endinterface
`default_nettype wire

// File: rtl/pose2grid_quant.sv
`default_nettype none
// ------------------------------------------------------------------
// pose2grid_quant: one axis of origin subtract, floor shift, range check.
// Option: POSE2GRID_DILATE_EN biases by half a cell. Rev 1.0
// ------------------------------------------------------------------
module pose2grid_quant #(
  parameter int     POS_W      = 32,
  parameter int     FRAC_W     = 16,
  parameter int     CELL_SHIFT = 0,
  parameter int     IDX_W      = 5,
  parameter longint ORIGIN     = 0
) (
  input  logic signed [POS_W-1:0] coord,
  input  logic                    offset,
  output logic [IDX_W-1:0]        idx,
  output logic                    inRange
);
  localparam int c_SH = FRAC_W + CELL_SHIFT;
  // Two guard bits: one for the origin subtract, one for the half-cell bias.
  localparam int c_W  = POS_W + 2;
  localparam logic signed [c_W-1:0] c_ORIGIN = c_W'(ORIGIN);

  logic signed [c_W-1:0] w_d;
  logic signed [c_W-1:0] w_base;
  logic signed [c_W-1:0] w_cand;

  assign w_d = {{2{coord[POS_W-1]}}, coord} - c_ORIGIN;

`ifdef POSE2GRID_DILATE_EN
  localparam logic signed [c_W-1:0] c_HALF = c_W'(64'd1 << (c_SH - 1));
  assign w_base = (w_d - c_HALF) >>> c_SH;
`else
  assign w_base = w_d >>> c_SH;
`endif

  assign w_cand  = w_base + c_W'({1'b0, offset});
  // Non-negative and below 2^IDX_W means every bit above the index is zero.
  assign inRange = (w_cand[c_W-1:IDX_W] == '0);
  assign idx     = w_cand[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/pose2grid_stream.sv
`default_nettype none
// ------------------------------------------------------------------
// pose2grid_stream: maps a frame of streamed 3-D points to grid cells.
// Option: POSE2GRID_DILATE_EN emits the 2x2x2 neighbourhood. Rev 1.0
// ------------------------------------------------------------------
module pose2grid_stream
  import pose2grid_pkg::*;
#(
  parameter int     POS_W      = 32,
  parameter int     FRAC_W     = 16,
  parameter int     CELL_SHIFT = 0,
  parameter int     GX_W       = 5,
  parameter int     GY_W       = 6,
  parameter int     GZ_W       = 5,
  parameter longint ORIGIN_X   = 0,
  parameter longint ORIGIN_Y   = 0,
  parameter longint ORIGIN_Z   = 0,
  parameter int     CNT_W      = 16
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               start,
  pose2grid_stream_if.slave  bus,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   pt_cnt,
  output logic [CNT_W-1:0]   oob_cnt
);
  state_t r_state, w_next, w_acceptNext;
  logic   r_last;
  logic   w_ptReady, w_ptHs, w_startHs, w_allIn, w_emitDone, w_oobInc;
  logic   w_inX, w_inY, w_inZ;
  logic [2:0] w_off;
  logic signed [POS_W-1:0] w_qX, w_qY, w_qZ;
  logic [GX_W-1:0] w_idxX;
  logic [GY_W-1:0] w_idxY;
  logic [GZ_W-1:0] w_idxZ;

  assign w_ptHs     = w_ptReady && bus.pt_valid;
  assign w_startHs  = (r_state == IDLE) && start;
  assign w_allIn    = w_inX && w_inY && w_inZ;
  assign bus.pt_ready = w_ptReady;

  pose2grid_quant #(.POS_W(POS_W), .FRAC_W(FRAC_W), .CELL_SHIFT(CELL_SHIFT),
                    .IDX_W(GX_W), .ORIGIN(ORIGIN_X))
    u_quantX (.coord(w_qX), .offset(w_off[2]), .idx(w_idxX), .inRange(w_inX));
  pose2grid_quant #(.POS_W(POS_W), .FRAC_W(FRAC_W), .CELL_SHIFT(CELL_SHIFT),
                    .IDX_W(GY_W), .ORIGIN(ORIGIN_Y))
    u_quantY (.coord(w_qY), .offset(w_off[1]), .idx(w_idxY), .inRange(w_inY));
  pose2grid_quant #(.POS_W(POS_W), .FRAC_W(FRAC_W), .CELL_SHIFT(CELL_SHIFT),
                    .IDX_W(GZ_W), .ORIGIN(ORIGIN_Z))
    u_quantZ (.coord(w_qZ), .offset(w_off[0]), .idx(w_idxZ), .inRange(w_inZ));

`ifdef POSE2GRID_DILATE_EN
  logic signed [POS_W-1:0] r_px, r_py, r_pz;
  logic [2:0] r_k;
  logic       r_hit;
  logic       w_step;

  // Quantise the held point so each candidate k is evaluated in its own cycle.
  assign w_qX = r_px;
  assign w_qY = r_py;
  assign w_qZ = r_pz;
  assign w_off = subOffset(r_k);
  assign w_step = (r_state == EMIT) && (!w_allIn || bus.cell_ready);
  assign w_emitDone   = w_step && (r_k == 3'd7);
  assign w_acceptNext = EMIT;
  assign w_oobInc     = w_emitDone && !r_hit && !w_allIn;
  assign bus.cell_valid = (r_state == EMIT) && w_allIn;
  assign bus.cell_x = (r_state == EMIT) ? w_idxX : '0;
  assign bus.cell_y = (r_state == EMIT) ? w_idxY : '0;
  assign bus.cell_z = (r_state == EMIT) ? w_idxZ : '0;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_px   <= '0;
      r_py   <= '0;
      r_pz   <= '0;
      r_last <= 1'b0;
      r_k    <= '0;
      r_hit  <= 1'b0;
    end else if (w_ptHs) begin
      r_px   <= bus.pt_x;
      r_py   <= bus.pt_y;
      r_pz   <= bus.pt_z;
      r_last <= bus.pt_last;
      r_k    <= '0;
      r_hit  <= 1'b0;
    end else if (w_step) begin
      r_k   <= r_k + 3'd1;
      r_hit <= r_hit | w_allIn;
    end
  end
`else
  logic [GX_W-1:0] r_cellX;
  logic [GY_W-1:0] r_cellY;
  logic [GZ_W-1:0] r_cellZ;

  // The live point is checked at acceptance so an out-of-range point never enters EMIT.
  assign w_qX = bus.pt_x;
  assign w_qY = bus.pt_y;
  assign w_qZ = bus.pt_z;
  assign w_off = 3'b000;
  assign w_emitDone   = (r_state == EMIT) && bus.cell_ready;
  assign w_acceptNext = w_allIn ? EMIT : (bus.pt_last ? DONE : ACCEPT);
  assign w_oobInc     = w_ptHs && !w_allIn;
  assign bus.cell_valid = (r_state == EMIT);
  assign bus.cell_x = r_cellX;
  assign bus.cell_y = r_cellY;
  assign bus.cell_z = r_cellZ;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cellX <= '0;
      r_cellY <= '0;
      r_cellZ <= '0;
      r_last  <= 1'b0;
    end else if (w_ptHs) begin
      r_cellX <= w_idxX;
      r_cellY <= w_idxY;
      r_cellZ <= w_idxZ;
      r_last  <= bus.pt_last;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ptReady  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = ACCEPT;
      end
      ACCEPT: begin
        w_ptReady = 1'b1;
        if (bus.pt_valid) w_next = w_acceptNext;
      end
      EMIT: begin
        if (w_emitDone) w_next = r_last ? DONE : ACCEPT;
      end
      DONE: begin
        frame_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pt_cnt  <= '0;
      oob_cnt <= '0;
    end else if (w_startHs) begin
      pt_cnt  <= '0;
      oob_cnt <= '0;
    end else begin
      if (w_ptHs)   pt_cnt  <= CNT_W'(satInc(64'(pt_cnt), CNT_W));
      if (w_oobInc) oob_cnt <= CNT_W'(satInc(64'(oob_cnt), CNT_W));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pose2grid_stream.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pose2grid_stream: directed frames with a queued cell model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_pose2grid_stream;
  localparam int POS_W = 32;
  localparam int GX_W  = 5;
  localparam int GY_W  = 6;
  localparam int GZ_W  = 5;
  localparam int CNT_W = 4;
`ifdef POSE2GRID_DILATE_EN
  localparam bit DIL = 1'b1;
`else
  localparam bit DIL = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] x;
    logic [5:0] y;
    logic [4:0] z;
  } cell_t;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done;
  logic [CNT_W-1:0] pt_cnt, oob_cnt;

  pose2grid_stream_if #(.POS_W(POS_W), .GX_W(GX_W), .GY_W(GY_W), .GZ_W(GZ_W)) bus ();

  pose2grid_stream #(
    .POS_W(POS_W), .FRAC_W(16), .CELL_SHIFT(0),
    .GX_W(GX_W), .GY_W(GY_W), .GZ_W(GZ_W),
    .ORIGIN_X(0), .ORIGIN_Y(0), .ORIGIN_Z(0), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .bus(bus.slave),
    .busy(busy), .frame_done(frame_done), .pt_cnt(pt_cnt), .oob_cnt(oob_cnt)
  );

  always #5 CLK = ~CLK;

  int    checks = 0;
  int    errors = 0;
  cell_t expQ[$];
  int    expPt, expOob;
  cell_t monCell;
  cell_t frontCell;
  int    n, fv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int axisBase(input logic signed [31:0] v);
    real r;
    r = real'(v) / 65536.0;
    if (DIL) r = r - 0.5;
    return int'($floor(r));
  endfunction

  function automatic logic [63:0] sat(input int v);
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  task automatic modelPoint(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    int bx, by, bz, cx, cy, cz, hits;
    cell_t c;
    hits = 0;
    bx = axisBase(x);
    by = axisBase(y);
    bz = axisBase(z);
    for (int k = 0; k < (DIL ? 8 : 1); k++) begin
      cx = bx + (k & 1);
      cy = by + ((k >> 1) & 1);
      cz = bz + ((k >> 2) & 1);
      if (cx >= 0 && cx < 32 && cy >= 0 && cy < 64 && cz >= 0 && cz < 32) begin
        c.x = cx[4:0];
        c.y = cy[5:0];
        c.z = cz[4:0];
        expQ.push_back(c);
        hits++;
      end
    end
    expPt++;
    if (hits == 0) expOob++;
  endtask

  always @(negedge CLK) begin
    if (RST_n === 1'b1 && bus.cell_valid === 1'b1 && bus.cell_ready === 1'b1) begin
      checks++;
      assert (expQ.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_cell: observed cell %0d/%0d/%0d, expected none",
               bus.cell_x, bus.cell_y, bus.cell_z);
      end
      if (expQ.size() > 0) begin
        monCell = expQ.pop_front();
        check("cell_fields", {bus.cell_x, bus.cell_y, bus.cell_z}, monCell);
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic sendPoint(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic last);
    bit got;
    got = 1'b0;
    modelPoint(x, y, z);
    bus.pt_x = x;
    bus.pt_y = y;
    bus.pt_z = z;
    bus.pt_last = last;
    bus.pt_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.pt_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("pt_accept", got, 1);
    @(posedge CLK); #1;
    bus.pt_valid = 1'b0;
    bus.pt_last = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    expPt = 0;
    expOob = 0;
  endtask

  // nOut: falling edges until frame_done; firstV: edge of first cell_valid (0 = none).
  task automatic waitDone(input int budget, output int nOut, output int firstV);
    bit seen;
    seen = 1'b0;
    nOut = 0;
    firstV = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      nOut++;
      if (firstV == 0 && bus.cell_valid === 1'b1) firstV = nOut;
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
    @(posedge CLK); #1;
  endtask

  initial begin
    bus.pt_valid = 1'b0;
    bus.pt_last = 1'b0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    bus.pt_z = '0;
    bus.cell_ready = 1'b1;
    expPt = 0;
    expOob = 0;

    repeat (3) @(negedge CLK);
    check("rst_pt_ready", bus.pt_ready, 0);
    check("rst_cell_valid", bus.cell_valid, 0);
    check("rst_cell_xyz", {bus.cell_x, bus.cell_y, bus.cell_z}, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_counts", {pt_cnt, oob_cnt}, 0);
    #1 RST_n = 1'b1;
    @(posedge CLK); #1;

    bus.pt_valid = 1'b1;
    bus.pt_x = 32'h0001_0000;
    repeat (3) begin
      @(negedge CLK);
      check("idle_pt_ready", bus.pt_ready, 0);
    end
    check("idle_pt_cnt", pt_cnt, 0);
    check("idle_busy", busy, 0);
    @(posedge CLK); #1;
    bus.pt_valid = 1'b0;

    doStart();
    @(negedge CLK);
    check("start_busy", busy, 1);
    check("start_pt_ready", bus.pt_ready, 1);
    @(posedge CLK); #1;
    sendPoint(32'h0003_0000, 32'h0005_0000, 32'h0007_0000, 1'b1);
    waitDone(20, n, fv);
    check("single_cell_latency", fv, 1);
    check("single_done_latency", n, DIL ? 9 : 2);
    @(negedge CLK);
    check("done_pulse_width", frame_done, 0);
    check("idle_after_done", busy, 0);
    check("single_pt_cnt", pt_cnt, sat(expPt));
    check("single_oob_cnt", oob_cnt, sat(expOob));
    @(posedge CLK); #1;

    doStart();
    sendPoint(32'hFFFF_8000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    waitDone(20, n, fv);
    check("neg_first_valid", fv, DIL ? 8 : 0);
    check("neg_done_latency", n, DIL ? 9 : 1);
    check("neg_pt_cnt", pt_cnt, sat(expPt));
    check("neg_oob_cnt", oob_cnt, sat(expOob));

    doStart();
    bus.cell_ready = 1'b0;
    sendPoint(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
    frontCell = expQ[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_valid", bus.cell_valid, 1);
      check("stall_fields", {bus.cell_x, bus.cell_y, bus.cell_z}, frontCell);
      check("stall_pt_ready", bus.pt_ready, 0);
    end
    @(posedge CLK); #1;
    bus.cell_ready = 1'b1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    sendPoint(32'h001F_0000, 32'h003F_0000, 32'h001F_FD70, 1'b0);
    sendPoint(32'h0020_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    sendPoint(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    waitDone(60, n, fv);
    check("frame_pt_cnt", pt_cnt, sat(expPt));
    check("frame_oob_cnt", oob_cnt, sat(expOob));

    doStart();
    sendPoint(32'h0003_C000, 32'h0005_4000, 32'h0007_8000, 1'b0);
    sendPoint(32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 1'b1);
    waitDone(40, n, fv);
    check("quarter_first_valid", fv, DIL ? 8 : 1);
    check("quarter_done_latency", n, DIL ? 9 : 2);
    check("quarter_oob_cnt", oob_cnt, sat(expOob));

    doStart();
    bus.cell_ready = 1'b0;
    sendPoint(32'h000A_0000, 32'h000A_0000, 32'h000A_0000, 1'b0);
    @(negedge CLK);
    check("pre_rst_valid", bus.cell_valid, 1);
    #2 RST_n = 1'b0;
    #1;
    check("mid_rst_pt_ready", bus.pt_ready, 0);
    check("mid_rst_cell_valid", bus.cell_valid, 0);
    check("mid_rst_cell_xyz", {bus.cell_x, bus.cell_y, bus.cell_z}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_counts", {pt_cnt, oob_cnt}, 0);
    expQ.delete();
    @(negedge CLK);
    #1 RST_n = 1'b1;
    @(posedge CLK); #1;
    bus.pt_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_pt_ready", bus.pt_ready, 0);
      check("post_rst_busy", busy, 0);
    end
    @(posedge CLK); #1;
    bus.pt_valid = 1'b0;
    bus.cell_ready = 1'b1;
    doStart();
    sendPoint(32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 1'b1);
    waitDone(20, n, fv);
    check("resume_pt_cnt", pt_cnt, sat(expPt));

    doStart();
    for (int i = 0; i < 17; i++)
      sendPoint(32'hFFFE_0000, 32'h0000_0000, 32'h0000_0000, (i == 16));
    waitDone(40, n, fv);
    check("sat_pt_cnt", pt_cnt, sat(expPt));
    check("sat_oob_cnt", oob_cnt, sat(expOob));
    doStart();
    @(negedge CLK);
    check("clear_pt_cnt", pt_cnt, sat(expPt));
    check("clear_oob_cnt", oob_cnt, sat(expOob));

    check("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
